ysyx_22040038_ctrl: RTL and testbench
=====================================

# ysyx_22040038_ctrl

Multi-cycle sequencer for the ysyx_22040038 RV64I core. It fetches an instruction over a valid/response handshake and holds it stable for the combinational decoder. It then steps the datapath through DECODE, EXEC, optional MEM and WB, and owns the PC, the register-file write strobe and the retired-instruction counter. It sits between the instruction/data memory ports and the decode/execute datapath, and stops the core on ebreak, an illegal opcode or a bus timeout.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000: PC loaded on reset.
- TIMEOUT, 16: maximum cycles waited for ifu_rvalid or lsu_done (≥ 2).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req  out  1  instruction fetch request, high only in FETCH.
- ifu_addr  out  64  fetch address (= pc).
- ifu_rvalid  in  1  fetch response valid.
- ifu_rdata  in  32  fetched instruction.
- instr_o  out  32  latched instruction, fed to decoder.
- pc  out  64  PC of the current instruction.
- next_pc_i  in  64  next PC computed by the datapath (pc+4, branch or jump target).
- lsu_req  out  1  data memory request, high only in MEM.
- lsu_we  out  1  1 = store, 0 = load; valid with lsu_req.
- lsu_done  in  1  data access complete.
- rf_wen  out  1  register write strobe, one-cycle pulse in WB.
- instret  out  64  retired-instruction count.
- halt  out  1  sticky; core stopped.
- illegal  out  1  sticky; halted on an unsupported opcode.
- bus_err  out  1  sticky; halted on a timeout.
- state_o  out  3  current state, for debug.

## Operation
- States and encodings: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset values:
  - state = BOOT, pc = RESET_PC.
  - instr_o = 32'h0000_0013 (nop), instret = 0.
  - halt, illegal, bus_err, wait counter all 0.
  - All request and strobe outputs are 0.
- BOOT → FETCH unconditionally after one cycle.
- FETCH:
  - ifu_req = 1.
  - On ifu_rvalid: instr_o ← ifu_rdata, → DECODE.
- DECODE: one cycle. Classify instr_o[6:0]:
  - Supported: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 0011011 OP-IMM-32, 0111011 OP-32 → EXEC.
  - instr_o == 32'h0010_0073 (ebreak) → HALT with halt = 1.
  - Any other value, including other 1110011 encodings → HALT with halt = 1 and illegal = 1.
- EXEC: one cycle, for datapath settling.
  - LOAD or STORE → MEM; otherwise → WB.
- MEM:
  - lsu_req = 1; lsu_we = 1 for STORE, 0 for LOAD.
  - On lsu_done → WB.
- WB: one cycle.
  - rf_wen = 1 unless the opcode is STORE or BRANCH.
  - pc ← next_pc_i, instret ← instret + 1, → FETCH.
- HALT: absorbing state; only reset leaves it.
  - All request and strobe outputs are 0.
  - pc, instr_o and instret are frozen.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle in FETCH or MEM without a response.
  - If the counter equals TIMEOUT−1 and no response arrives that cycle → HALT with halt = 1 and bus_err = 1.
  - A response arriving on that same cycle wins; no error is raised.
- ifu_rvalid is ignored outside FETCH; lsu_done is ignored outside MEM.
- Widths:
  - pc is updated only from next_pc_i; the block adds nothing to it.
  - instret wraps modulo 2^64.

## Timing
- State and all registered outputs update on the rising edge of clk. rst_n clears them asynchronously; release is taken at the next edge.
- ifu_req, lsu_req, lsu_we, rf_wen and state_o decode directly from state, with no extra latency.
- ifu_addr and pc are stable for the whole instruction, from FETCH through WB.
- instr_o is valid from the first DECODE cycle until the next FETCH completes.
- Minimum latency per instruction, with the response arriving in the first request cycle:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- A response arriving after k stall cycles adds k cycles.
- The longest wait before a timeout is TIMEOUT cycles in the request state.
- Requests stay asserted until the response cycle. The deassertion edge is the one that samples the response.
- The first FETCH cycle is the second rising edge after rst_n deasserts (BOOT occupies one cycle).
- Reset asserted mid-instruction:
  - Request outputs drop immediately.
  - No rf_wen pulse and no pc update occur.

## Test plan
- Reset, then addi x1,x0,1 (32'h0010_0093) returned in the first FETCH cycle, with next_pc_i = pc+4:
  - FETCH, DECODE, EXEC, WB sequence: 1, 2, 3, 5.
  - rf_wen pulses once in WB.
  - pc = 64'h8000_0004 and instret = 1.
- sd (32'h00113023), with lsu_done held low for 3 cycles:
  - lsu_req high for 4 cycles with lsu_we = 1.
  - WB with rf_wen = 0; 8 cycles total (FETCH, DECODE, EXEC, 4×MEM, WB).
- ld (32'h0000b083), with lsu_done on the first MEM cycle:
  - lsu_we = 0; rf_wen = 1.
  - 5-cycle instruction.
- ebreak (32'h0010_0073):
  - HALT with halt = 1, illegal = 0.
  - ifu_req stays 0 for 20 further cycles; instret unchanged.
- Instruction 32'hFFFF_FFFF → halt = 1, illegal = 1, bus_err = 0.
- Timeout boundary with TIMEOUT = 16:
  - ifu_rvalid never asserted → HALT with bus_err = 1 after exactly 16 FETCH cycles.
  - Repeat with ifu_rvalid on the 16th FETCH cycle → DECODE, no error.

Source files
------------

// File: rtl/ysyx_22040038_ctrl_if.sv
// +------------------------------------------------------------------+
// | ysyx_22040038_ctrl_if : fetch / data-memory handshake bundle     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface ysyx_22040038_ctrl_if;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_done;

  modport master (
    output ifu_req, ifu_addr, lsu_req, lsu_we,
    input  ifu_rvalid, ifu_rdata, lsu_done
  );

  modport slave (
    input  ifu_req, ifu_addr, lsu_req, lsu_we,
    output ifu_rvalid, ifu_rdata, lsu_done
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22040038_ctrl.sv
// +------------------------------------------------------------------+
// | ysyx_22040038_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ysyx_22040038_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_22040038_ctrl_if.master        bus,
  output logic [31:0]                 instr_o,
  output logic [63:0]                 pc,
  input  logic [63:0]                 next_pc_i,
  output logic                        rf_wen,
  output logic [63:0]                 instret,
  output logic                        halt,
  output logic                        illegal,
  output logic                        bus_err,
  output logic [2:0]                  state_o
);

  localparam logic [2:0] c_BOOT   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_EXEC   = 3'd3;
  localparam logic [2:0] c_MEM    = 3'd4;
  localparam logic [2:0] c_WB     = 3'd5;
  localparam logic [2:0] c_HALT   = 3'd6;

  localparam logic [6:0] c_OP_LUI     = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] c_OP_JAL     = 7'b1101111;
  localparam logic [6:0] c_OP_JALR    = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD    = 7'b0000011;
  localparam logic [6:0] c_OP_STORE   = 7'b0100011;
  localparam logic [6:0] c_OP_IMM     = 7'b0010011;
  localparam logic [6:0] c_OP_OP      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM32   = 7'b0011011;
  localparam logic [6:0] c_OP_OP32    = 7'b0111011;

  localparam logic [31:0] c_EBREAK = 32'h0010_0073;
  localparam logic [31:0] c_NOP    = 32'h0000_0013;

  localparam int               c_CNT_W    = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [63:0]        r_pc;
  logic [31:0]        r_instr;
  logic [63:0]        r_instret;
  logic               r_halt;
  logic               r_illegal;
  logic               r_bus_err;
  logic [c_CNT_W-1:0] r_wait_cnt;

  logic [6:0]         w_opcode;
  logic               w_supported;
  logic               w_is_load;
  logic               w_is_store;
  logic               w_is_branch;

  always_comb begin
    w_opcode    = r_instr[6:0];
    w_supported = 1'b0;
    case (w_opcode)
      c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_BRANCH,
      c_OP_LOAD, c_OP_STORE, c_OP_IMM, c_OP_OP, c_OP_IMM32,
      c_OP_OP32: w_supported = 1'b1;
      default:   w_supported = 1'b0;
    endcase
  end

  assign w_is_load   = (w_opcode == c_OP_LOAD);
  assign w_is_store  = (w_opcode == c_OP_STORE);
  assign w_is_branch = (w_opcode == c_OP_BRANCH);

  // Handshake and strobe outputs are pure state decodes so reset drops them at once.
  assign bus.ifu_req  = (r_state == c_FETCH);
  assign bus.ifu_addr = r_pc;
  assign bus.lsu_req  = (r_state == c_MEM);
  assign bus.lsu_we   = (r_state == c_MEM) && w_is_store;
  assign rf_wen       = (r_state == c_WB) && !(w_is_store || w_is_branch);

  assign instr_o = r_instr;
  assign pc      = r_pc;
  assign instret = r_instret;
  assign halt    = r_halt;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign state_o = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_BOOT;
      r_pc       <= RESET_PC;
      r_instr    <= c_NOP;
      r_instret  <= 64'd0;
      r_halt     <= 1'b0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        c_BOOT: begin
          r_wait_cnt <= '0;
          r_state    <= c_FETCH;
        end
        c_FETCH: begin
          // A response on the last allowed cycle takes priority over the timeout.
          if (bus.ifu_rvalid) begin
            r_instr    <= bus.ifu_rdata;
            r_wait_cnt <= '0;
            r_state    <= c_DECODE;
          end else if (r_wait_cnt == c_WAIT_MAX) begin
            r_halt    <= 1'b1;
            r_bus_err <= 1'b1;
            r_state   <= c_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
          end
        end
        c_DECODE: begin
          if (w_supported) begin
            r_state <= c_EXEC;
          end else begin
            r_halt    <= 1'b1;
            r_illegal <= (r_instr != c_EBREAK);
            r_state   <= c_HALT;
          end
        end
        c_EXEC: begin
          r_wait_cnt <= '0;
          r_state    <= (w_is_load || w_is_store) ? c_MEM : c_WB;
        end
        c_MEM: begin
          if (bus.lsu_done) begin
            r_wait_cnt <= '0;
            r_state    <= c_WB;
          end else if (r_wait_cnt == c_WAIT_MAX) begin
            r_halt    <= 1'b1;
            r_bus_err <= 1'b1;
            r_state   <= c_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
          end
        end
        c_WB: begin
          r_pc       <= next_pc_i;
          r_instret  <= r_instret + 64'd1;
          r_wait_cnt <= '0;
          r_state    <= c_FETCH;
        end
        c_HALT: begin
          r_state <= c_HALT;
        end
        default: begin
          r_halt  <= 1'b1;
          r_state <= c_HALT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040038_ctrl.sv
// +------------------------------------------------------------------+
// | tb_ysyx_22040038_ctrl : randomized self-checking bench for ctrl   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22040038_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          TIMEOUT  = 16;

  localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [31:0] I_ADDI   = 32'h0010_0093;
  localparam logic [31:0] I_SD     = 32'h0011_3023;
  localparam logic [31:0] I_LD     = 32'h0000_b083;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_o;
  logic [63:0] pc;
  logic [63:0] next_pc_i;
  logic        rf_wen;
  logic [63:0] instret;
  logic        halt, illegal, bus_err;
  logic [2:0]  state_o;

  ysyx_22040038_ctrl_if bus ();

  ysyx_22040038_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .instr_o   (instr_o),
    .pc        (pc),
    .next_pc_i (next_pc_i),
    .rf_wen    (rf_wen),
    .instret   (instret),
    .halt      (halt),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0]  trace[$];
  logic [2:0]  exp_trace[$];
  int          obs_wen, obs_lsu, obs_we1, obs_addr_bad, obs_hung;
  logic [31:0] obs_instr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_supported(input logic [6:0] op);
    logic [6:0] ops [11];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011};
    for (int i = 0; i < 11; i++) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ifu_rvalid = 1'b0;
    bus.lsu_done   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Plays memory for one instruction, reacting to the DUT's requests, and records what it saw.
  task automatic run_instr(input logic [31:0] ins, input int fst, input int mst, input logic [63:0] npc);
    int fc, mc;
    bit done;
    logic [63:0] pc0;
    fc = 0; mc = 0; done = 0;
    trace.delete();
    obs_wen = 0; obs_lsu = 0; obs_we1 = 0; obs_addr_bad = 0; obs_hung = 0; obs_instr = '0;
    pc0 = pc;
    next_pc_i = npc;
    bus.ifu_rdata = ins;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (state_o == S_HALT) begin
        done = 1;
      end else begin
        trace.push_back(state_o);
        bus.ifu_rvalid = (state_o == S_FETCH) && (fc == fst);
        bus.lsu_done   = (state_o == S_MEM) && (mc == mst);
        if (state_o == S_FETCH) fc++;
        if (state_o == S_MEM) mc++;
        if (bus.lsu_req) begin
          obs_lsu++;
          if (bus.lsu_we) obs_we1++;
        end
        if (rf_wen) obs_wen++;
        if (bus.ifu_addr !== pc0 || pc !== pc0) obs_addr_bad++;
        if (state_o == S_DECODE) obs_instr = instr_o;
        if (state_o == S_WB) done = 1;
        @(negedge clk);
      end
    end
    if (!done) obs_hung = 1;
    bus.ifu_rvalid = 1'b0;
    bus.lsu_done   = 1'b0;
  endtask

  task automatic exec_check(input string tag, input logic [31:0] ins, input int fst,
                            input int mst, input logic [63:0] npc);
    logic [63:0] pc_b, ir_b, ins_b;
    logic [6:0]  op;
    bit sup, mem, store, wr, tmo;
    int bad;
    pc_b  = pc;
    ir_b  = instret;
    ins_b = {32'd0, instr_o};
    op    = ins[6:0];
    sup   = is_supported(op);
    store = (op == 7'b0100011);
    mem   = store || (op == 7'b0000011);
    wr    = !(store || op == 7'b1100011);
    tmo   = (fst >= TIMEOUT);

    exp_trace.delete();
    if (tmo) begin
      for (int i = 0; i < TIMEOUT; i++) exp_trace.push_back(S_FETCH);
    end else begin
      for (int i = 0; i <= fst; i++) exp_trace.push_back(S_FETCH);
      exp_trace.push_back(S_DECODE);
      if (sup) begin
        exp_trace.push_back(S_EXEC);
        if (mem) for (int i = 0; i <= mst; i++) exp_trace.push_back(S_MEM);
        exp_trace.push_back(S_WB);
      end
    end

    run_instr(ins, fst, mst, npc);

    check({tag, ".hung"}, 64'(obs_hung), 64'd0);
    check({tag, ".trace_len"}, 64'(trace.size()), 64'(exp_trace.size()));
    bad = 0;
    for (int i = 0; i < exp_trace.size() && i < trace.size(); i++)
      if (trace[i] !== exp_trace[i]) bad++;
    check({tag, ".trace_bad"}, 64'(bad), 64'd0);
    check({tag, ".addr_stable"}, 64'(obs_addr_bad), 64'd0);

    if (tmo) begin
      check({tag, ".halt"}, 64'(halt), 64'd1);
      check({tag, ".bus_err"}, 64'(bus_err), 64'd1);
      check({tag, ".illegal"}, 64'(illegal), 64'd0);
      check({tag, ".instr_keep"}, 64'(instr_o), ins_b);
      check({tag, ".instret"}, instret, ir_b);
    end else if (!sup) begin
      check({tag, ".halt"}, 64'(halt), 64'd1);
      check({tag, ".illegal"}, 64'(illegal), 64'(ins != I_EBREAK));
      check({tag, ".bus_err"}, 64'(bus_err), 64'd0);
      check({tag, ".instr"}, 64'(instr_o), 64'(ins));
      check({tag, ".pc"}, pc, pc_b);
      check({tag, ".instret"}, instret, ir_b);
      check({tag, ".wen"}, 64'(obs_wen), 64'd0);
    end else begin
      check({tag, ".instr"}, 64'(obs_instr), 64'(ins));
      check({tag, ".wen"}, 64'(obs_wen), 64'(wr));
      check({tag, ".lsu_cycles"}, 64'(obs_lsu), mem ? 64'(mst + 1) : 64'd0);
      check({tag, ".lsu_we"}, 64'(obs_we1), store ? 64'(mst + 1) : 64'd0);
      check({tag, ".pc"}, pc, npc);
      check({tag, ".instret"}, instret, ir_b + 64'd1);
      check({tag, ".halt"}, 64'(halt), 64'd0);
    end
  endtask

  initial begin
    int req_seen;
    logic [63:0] pc_h, ir_h;
    logic [31:0] ins_r;
    logic [6:0]  ops_r [11];
    int fst, mst;

    ops_r = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
              7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011};
    clk = 1'b0;
    rst_n = 1'b0;
    next_pc_i = '0;
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = '0;
    bus.lsu_done   = 1'b0;
    repeat (2) @(negedge clk);

    check("rst.state", 64'(state_o), 64'(S_BOOT));
    check("rst.pc", pc, RESET_PC);
    check("rst.instr", 64'(instr_o), 64'h13);
    check("rst.instret", instret, 64'd0);
    check("rst.flags", {61'd0, halt, illegal, bus_err}, 64'd0);
    check("rst.strobes", {60'd0, bus.ifu_req, bus.lsu_req, bus.lsu_we, rf_wen}, 64'd0);
    rst_n = 1'b1;
    check("boot.state", 64'(state_o), 64'(S_BOOT));
    @(negedge clk);
    check("first_fetch", 64'(state_o), 64'(S_FETCH));

    exec_check("addi", I_ADDI, 0, 0, pc + 64'd4);
    check("addi.pc_abs", pc, 64'h0000_0000_8000_0004);
    check("addi.instret_abs", instret, 64'd1);
    exec_check("sd", I_SD, 0, 3, pc + 64'd4);
    exec_check("ld", I_LD, 0, 0, pc + 64'd4);

    for (int n = 0; n < 30; n++) begin
      ins_r = $urandom();
      ins_r[6:0] = ops_r[$urandom_range(0, 10)];
      fst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      mst = int'($urandom_range(0, 4));
      exec_check("rand", ins_r, fst, mst, {$urandom(), $urandom()});
    end

    exec_check("ebreak", I_EBREAK, 1, 0, pc + 64'd4);
    pc_h = pc;
    ir_h = instret;
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      bus.ifu_rvalid = 1'($urandom_range(0, 1));
      bus.lsu_done   = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.ifu_req || bus.lsu_req || rf_wen) req_seen++;
    end
    bus.ifu_rvalid = 1'b0;
    bus.lsu_done   = 1'b0;
    check("halt.no_req", 64'(req_seen), 64'd0);
    check("halt.state", 64'(state_o), 64'(S_HALT));
    check("halt.pc", pc, pc_h);
    check("halt.instret", instret, ir_h);
    check("halt.instr", 64'(instr_o), 64'(I_EBREAK));

    do_reset();
    exec_check("illegal", 32'hFFFF_FFFF, 0, 0, 64'd0);

    do_reset();
    exec_check("timeout", I_ADDI, 1000, 0, 64'd0);

    do_reset();
    exec_check("last_cycle", I_ADDI, TIMEOUT - 1, 0, pc + 64'd4);
    check("last_cycle.bus_err", 64'(bus_err), 64'd0);

    do_reset();
    bus.ifu_rdata  = I_LD;
    bus.ifu_rvalid = 1'b1;
    next_pc_i = 64'h1234;
    @(negedge clk);
    bus.ifu_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid.lsu_req_before", 64'(bus.lsu_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid.strobes", {61'd0, bus.ifu_req, bus.lsu_req, rf_wen}, 64'd0);
    check("mid.state", 64'(state_o), 64'(S_BOOT));
    check("mid.pc", pc, RESET_PC);
    check("mid.instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
